// File: rtl/line_memory_pkg.sv
// Shared types and default geometry for the line-granular main-memory model.
package mem_pkg;

   localparam int unsigned ADDRESS_SIZE  = 32;
   localparam int unsigned REGISTER_SIZE = 32;
   localparam int unsigned REGS_PER_LINE = 4;
   localparam int unsigned LINE_LENGTH   = REGS_PER_LINE * REGISTER_SIZE;
   localparam int unsigned MEM_LINES     = 256;
   localparam int unsigned LATENCY       = 5;

   // Byte-offset bits inside one line.
   function automatic int unsigned offset_bits(input int unsigned line_length);
      return $clog2(line_length / 8);
   endfunction

   // Latency counter width; a single bit is kept even when LATENCY is 1.
   function automatic int unsigned count_bits(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

   localparam int unsigned OFF        = offset_bits(LINE_LENGTH);
   localparam int unsigned INDEX_BITS = $clog2(MEM_LINES);
   localparam int unsigned COUNT_BITS = count_bits(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/line_memory_if.sv
// Cache-to-memory line transaction bus (four-phase request/satisfied).
interface line_memory_if #(
   parameter int unsigned ADDRESS_SIZE = mem_pkg::ADDRESS_SIZE,
   parameter int unsigned LINE_LENGTH  = mem_pkg::LINE_LENGTH
);

   logic                    mem_request;
   logic                    mem_write;
   logic [ADDRESS_SIZE-1:0] mem_address;
   logic [LINE_LENGTH-1:0]  mem_data;
   logic [LINE_LENGTH-1:0]  mem_result;
   logic                    mem_satisfied;

   // Cache side drives the request.
   modport master (
      output mem_request,
      output mem_write,
      output mem_address,
      output mem_data,
      input  mem_result,
      input  mem_satisfied
   );

   // Memory side answers it.
   modport slave (
      input  mem_request,
      input  mem_write,
      input  mem_address,
      input  mem_data,
      output mem_result,
      output mem_satisfied
   );

endinterface

// File: rtl/line_memory_ram.sv
// Single-port line-wide storage with a registered read/echo port.
module line_ram #(
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned REGS_PER_LINE = 4,
   parameter int unsigned MEM_LINES     = 256
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      en,
   input  logic                                      we,
   input  logic [$clog2(MEM_LINES)-1:0]              addr,
   input  logic [REGS_PER_LINE*REGISTER_SIZE-1:0]    wdata,
   output logic [REGS_PER_LINE*REGISTER_SIZE-1:0]    rdata
);

   localparam int unsigned LINE_LENGTH = REGS_PER_LINE * REGISTER_SIZE;

   typedef logic [MEM_LINES-1:0][LINE_LENGTH-1:0] line_array_t;

   // Power-up image: word j of line i holds i*REGS_PER_LINE + j.
   function automatic line_array_t initial_lines();
      line_array_t image;
      image = '0;
      for (int unsigned i = 0; i < MEM_LINES; i++) begin
         for (int unsigned j = 0; j < REGS_PER_LINE; j++) begin
            image[i][j*REGISTER_SIZE +: REGISTER_SIZE] =
               REGISTER_SIZE'(i * REGS_PER_LINE + j);
         end
      end
      return image;
   endfunction

   // Contents come from the power-up image only; reset never touches them.
   line_array_t lines = initial_lines();

   // Line write on a completing writeback; an aborting reset blocks it.
   always_ff @(posedge clk) begin
      if (!reset && en && we) begin
         lines[addr] <= wdata;
      end
   end

   // Result register: echo on write, array read on fill, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (en) begin
         if (we) begin
            rdata <= wdata;
         end else begin
            rdata <= lines[addr];
         end
      end
   end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency main-memory model servicing whole-line fills and writebacks.
module line_memory #(
   parameter int unsigned ADDRESS_SIZE  = 32,
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned REGS_PER_LINE = 4,
   parameter int unsigned MEM_LINES     = 256,
   parameter int unsigned LATENCY       = 5
) (
   input  logic          clk,
   input  logic          reset,
   line_memory_if.slave  bus
);

   import mem_pkg::*;

   localparam int unsigned LINE_BITS = REGS_PER_LINE * REGISTER_SIZE;
   localparam int unsigned OFF_BITS  = offset_bits(LINE_BITS);
   localparam int unsigned IDX_BITS  = $clog2(MEM_LINES);
   localparam int unsigned CNT_BITS  = count_bits(LATENCY);

   state_t                 state;
   state_t                 next_state;
   logic [CNT_BITS-1:0]    count;
   logic [CNT_BITS-1:0]    count_d;
   logic                   accept_c;
   logic                   complete_c;
   logic                   satisfied;
   logic [IDX_BITS-1:0]    index;
   logic                   write;
   logic [LINE_BITS-1:0]   data;
   logic [LINE_BITS-1:0]   result;
   logic                   unused_addr_c;

   // State, latency counter and registered completion flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         satisfied <= 1'b0;
      end else begin
         state     <= next_state;
         count     <= count_d;
         satisfied <= (next_state == DONE);
      end
   end

   // Next-state, counter update and accept/complete strobes.
   always_comb begin
      next_state = state;
      count_d    = count;
      accept_c   = 1'b0;
      complete_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_request) begin
               next_state = BUSY;
               count_d    = CNT_BITS'(LATENCY - 1);
               accept_c   = 1'b1;
            end
         end
         BUSY: begin
            if (count == '0) begin
               next_state = DONE;
               complete_c = 1'b1;
            end else begin
               count_d = count - CNT_BITS'(1);
            end
         end
         DONE: begin
            if (!bus.mem_request) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Capture the transaction on accept; bus changes afterwards are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         index <= '0;
         write <= 1'b0;
         data  <= '0;
      end else if (accept_c) begin
         index <= bus.mem_address[OFF_BITS +: IDX_BITS];
         write <= bus.mem_write;
         data  <= bus.mem_data;
      end
   end

   line_ram #(
      .REGISTER_SIZE (REGISTER_SIZE),
      .REGS_PER_LINE (REGS_PER_LINE),
      .MEM_LINES     (MEM_LINES)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .en    (complete_c),
      .we    (write),
      .addr  (index),
      .wdata (data),
      .rdata (result)
   );

   assign bus.mem_result    = result;
   assign bus.mem_satisfied = satisfied;

   // Offset and upper address bits do not select a line.
   assign unused_addr_c = ^{bus.mem_address, ADDRESS_SIZE'(0)};

endmodule

// File: doc/line_memory.md
# line_memory

Main-memory model that sits directly downstream of the direct-mapped data cache and services its line fills and line writebacks. It accepts one whole-line transaction at a time over a four-phase request/satisfied handshake. It responds after a fixed, parameterised latency, giving the cache a deterministic miss penalty in simulation. Storage is a line-wide array indexed by the line-aligned address.

## Interface
- ADDRESS_SIZE, 32, byte-address width
- REGISTER_SIZE, 32, word width in bits
- REGS_PER_LINE, 4, words per cache line
- LINE_LENGTH, REGS_PER_LINE*REGISTER_SIZE, line width in bits
- MEM_LINES, 256, number of stored lines (power of two)
- LATENCY, 5, cycles from accept to response (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_request  in  1  cache requests a transaction
- mem_write  in  1  1 = writeback line, 0 = line fill
- mem_address  in  ADDRESS_SIZE  byte address of the line
- mem_data  in  LINE_LENGTH  line to write (word j at bits [j*REGISTER_SIZE +: REGISTER_SIZE])
- mem_result  out  LINE_LENGTH  returned line, same packing
- mem_satisfied  out  1  transaction complete, mem_result valid

One clock; reset is synchronous and active-high.

## Operation
- Line offset bits: OFF = log2(LINE_LENGTH/8), which is 4 at the defaults. Index: mem_address[OFF +: log2(MEM_LINES)]. Upper bits are ignored, so the address wraps modulo MEM_LINES.
- Initial contents, set at time zero and not by reset: word j of line i = i*REGS_PER_LINE + j. Reset does not alter the array.
- FSM states:
  - IDLE → BUSY when mem_request=1. The FSM latches index, mem_write and mem_data, and loads count = LATENCY-1.
  - BUSY: if count==0 → DONE, else count--. Input changes during BUSY are ignored.
  - On the BUSY→DONE edge:
    - Write: array[index] ← latched data, and mem_result ← latched data (echo).
    - Read: mem_result ← array[index].
  - DONE: mem_satisfied=1. Stay in DONE while mem_request=1; go to IDLE when mem_request=0.
- A request dropped during BUSY still completes. DONE then lasts exactly one cycle.
- Only one outstanding transaction; no queueing.

## Timing
- Reset (sync): state IDLE, count 0, mem_satisfied 0, mem_result 0.
- Reset mid-BUSY aborts the transaction. A pending write is not performed.
- Request sampled at edge N → mem_satisfied high after edge N+LATENCY.
- mem_satisfied falls on the first edge where the FSM is in DONE with mem_request=0.
- mem_result holds its value after DONE until the next completion or reset.
- Back-to-back: after DONE→IDLE, the next request is accepted at the following edge, so there is at least one IDLE cycle between transactions.
- mem_satisfied is registered; there is no combinational path from any input to any output.

## Structure
- Package mem_pkg:
  - State typedef {IDLE, BUSY, DONE}.
  - Derived constants: LINE_LENGTH, OFF, INDEX_BITS, COUNT_BITS = clog2(LATENCY).
- One sub-module, line_ram: single-port, LINE_LENGTH-wide, MEM_LINES-deep array.
  - Synchronous write; read registered on the completion edge.
  - Contains the initial-contents loop.
- Top level holds the FSM, latency counter, request latches and output registers.

## Test plan
Bench parameters: LATENCY=3, MEM_LINES=16, defaults otherwise.

1. Reset high for 2 cycles → mem_satisfied=0, mem_result=0. With request held high during reset, no transaction starts.
2. Read 0x10 (line 1), request sampled at edge N → satisfied rises after edge N+3, mem_result=128'h00000007_00000006_00000005_00000004. Satisfied holds while request stays high and clears one edge after request drops.
3. Write 0x20 with mem_data=128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0 → satisfied after 3 edges and mem_result echoes the data. A subsequent read of 0x24 returns the same line.
4. Read 0x110 → index wraps to line 1 and returns the same line as scenario 2.
5. Write line 3 (0x30), then assert reset 1 cycle into BUSY → satisfied stays 0. A later read of 0x30 returns the initial line 128'h0000000F_0000000E_0000000D_0000000C.
6. Request pulsed high for one cycle only → satisfied high for exactly one cycle, after edge N+3. A new request accepted the cycle after return to IDLE completes normally.
